// File: rtl/shift_frame_sched_if.sv
// Request/ack and shift-register control bundle between two requesters,
// the frame scheduler and the shift register it drives.
interface shift_frame_sched_if #(
    parameter int NBITS = 4
);
    logic             Req0;
    logic             Req1;
    logic [NBITS-1:0] Data0;
    logic [NBITS-1:0] Data1;
    logic             Ack0;
    logic             Ack1;
    logic             Load;
    logic             ShiftEn;
    logic [NBITS-1:0] ParallelIn;
    logic             ShiftIn;
    logic             SerValid;
    logic             SerLast;
    logic             SerSrc;
    logic             Busy;

    modport master (
        output Req0, Req1, Data0, Data1,
        input  Ack0, Ack1, Load, ShiftEn, ParallelIn, ShiftIn,
        input  SerValid, SerLast, SerSrc, Busy
    );

    modport slave (
        input  Req0, Req1, Data0, Data1,
        output Ack0, Ack1, Load, ShiftEn, ParallelIn, ShiftIn,
        output SerValid, SerLast, SerSrc, Busy
    );
endinterface

// File: rtl/shift_frame_sched.sv
// Round-robin scheduler sharing one MSB-first parallel-load shift register
// between two requesters; every output is registered from the next state.
module shift_frame_sched #(
    parameter int NBITS    = 4,
    parameter int IDLE_GAP = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    shift_frame_sched_if.slave    bus
);
    localparam int CNT_W = $clog2((NBITS > IDLE_GAP) ? NBITS : IDLE_GAP);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               last_grant_reg, last_grant_next;
    logic               grant_valid;
    logic               grant;
    logic [NBITS-1:0]   grant_data;
    logic [1:0]         ack_set;
    logic [1:0]         ack_reg;
    logic               load_reg;
    logic               shift_en_reg;
    logic               ser_last_reg;
    logic               ser_src_reg;
    logic               busy_reg;
    logic [NBITS-1:0]   parallel_in_reg;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        grant_valid     = 1'b0;
        grant           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    grant_valid     = 1'b1;
                    // On a tie the requester not served last wins.
                    grant           = (bus.Req0 && bus.Req1) ? ~last_grant_reg : bus.Req1;
                    last_grant_next = grant;
                    state_next      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_next   = LAST_BIT;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_reg == '0) begin
                    if (IDLE_GAP == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_GAP;
                        cnt_next   = GAP_INIT;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign grant_data = grant ? bus.Data1 : bus.Data0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_set[gi] = grant_valid && (grant == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            last_grant_reg  <= 1'b1;
            ack_reg         <= '0;
            load_reg        <= 1'b0;
            shift_en_reg    <= 1'b0;
            ser_last_reg    <= 1'b0;
            ser_src_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            parallel_in_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            ack_reg        <= ack_set;
            load_reg       <= (state_next == ST_LOAD);
            shift_en_reg   <= (state_next == ST_SHIFT);
            ser_last_reg   <= (state_next == ST_SHIFT) && (cnt_next == '0);
            busy_reg       <= (state_next != ST_IDLE);
            // The output word register doubles as the hold register.
            if (grant_valid) begin
                parallel_in_reg <= grant_data;
                ser_src_reg     <= grant;
            end
        end
    end

    assign bus.Ack0       = ack_reg[0];
    assign bus.Ack1       = ack_reg[1];
    assign bus.Load       = load_reg;
    assign bus.ShiftEn    = shift_en_reg;
    assign bus.ParallelIn = parallel_in_reg;
    assign bus.ShiftIn    = 1'b0;
    assign bus.SerValid   = shift_en_reg;
    assign bus.SerLast    = ser_last_reg;
    assign bus.SerSrc     = ser_src_reg;
    assign bus.Busy       = busy_reg;
endmodule

// File: tb/tb_shift_frame_sched.sv
// Directed bench for shift_frame_sched: one instance with the default gap,
// one with IDLE_GAP=0, and a model of the shift register being driven.
module tb_shift_frame_sched;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    shift_frame_sched_if #(.NBITS(NB)) bus_a ();
    shift_frame_sched_if #(.NBITS(NB)) bus_b ();

    shift_frame_sched #(.NBITS(NB), .IDLE_GAP(1)) dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .bus     (bus_a)
    );

    shift_frame_sched #(.NBITS(NB), .IDLE_GAP(0)) dut_b (
        .clk     (clk),
        .reset_n (rst_b_n),
        .bus     (bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // External shift register driven by dut_a.
    logic [NB-1:0] sr_a;
    always @(posedge clk) begin
        if (bus_a.Load)
            sr_a <= bus_a.ParallelIn;
        else if (bus_a.ShiftEn)
            sr_a <= {sr_a[NB-2:0], bus_a.ShiftIn};
    end

    logic [12:0] outs_a;
    assign outs_a = {bus_a.Ack0, bus_a.Ack1, bus_a.Load, bus_a.ShiftEn, bus_a.ParallelIn,
                     bus_a.ShiftIn, bus_a.SerValid, bus_a.SerLast, bus_a.SerSrc, bus_a.Busy};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 20 && bus_a.Busy !== 1'b0; i++) tick();
        chk("idle_timeout", bus_a.Busy, 0);
    endtask

    // One requester-0 frame; Data0 is switched to alt right after the Ack.
    task automatic frame0(input logic [NB-1:0] w, input logic [NB-1:0] alt, input string name);
        bus_a.Req0  = 1'b1;
        bus_a.Data0 = w;
        tick();
        chk({name, "_load"}, bus_a.Load, 1);
        chk({name, "_ack0"}, bus_a.Ack0, 1);
        chk({name, "_ack1"}, bus_a.Ack1, 0);
        chk({name, "_pin"}, bus_a.ParallelIn, w);
        chk({name, "_shen_in_load"}, bus_a.ShiftEn, 0);
        chk({name, "_busy"}, bus_a.Busy, 1);
        bus_a.Req0  = 1'b0;
        bus_a.Data0 = alt;
        for (int k = 0; k < NB; k++) begin
            tick();
            chk({name, "_valid"}, bus_a.SerValid, 1);
            chk({name, "_shen"}, bus_a.ShiftEn, 1);
            chk({name, "_noload"}, bus_a.Load, 0);
            chk({name, "_noack"}, bus_a.Ack0, 0);
            chk({name, "_bit"}, sr_a[NB-1], w[NB-1-k]);
            chk({name, "_last"}, bus_a.SerLast, (k == NB - 1));
            chk({name, "_src"}, bus_a.SerSrc, 0);
        end
        tick();
        chk({name, "_gap_busy"}, bus_a.Busy, 1);
        chk({name, "_gap_valid"}, bus_a.SerValid, 0);
        chk({name, "_gap_load"}, bus_a.Load, 0);
        tick();
        chk({name, "_idle_busy"}, bus_a.Busy, 0);
        chk({name, "_hold_pin"}, bus_a.ParallelIn, w);
        $display("frame %s: src=0 word=%b", name, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        logic exp_src;

        rst_a_n     = 1'b0;
        rst_b_n     = 1'b0;
        bus_a.Req0  = 1'b0;
        bus_a.Req1  = 1'b0;
        bus_a.Data0 = '0;
        bus_a.Data1 = '0;
        bus_b.Req0  = 1'b0;
        bus_b.Req1  = 1'b0;
        bus_b.Data0 = '0;
        bus_b.Data1 = '0;

        // Reset held 3 cycles with both requests up.
        bus_a.Req0  = 1'b1;
        bus_a.Req1  = 1'b1;
        bus_a.Data0 = 4'b1011;
        bus_a.Data1 = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outs", outs_a, 0);
        end
        rst_a_n = 1'b1;
        tick();
        chk("rst_rel_ack0", bus_a.Ack0, 1);
        chk("rst_rel_ack1", bus_a.Ack1, 0);
        chk("rst_rel_load", bus_a.Load, 1);
        $display("reset release: first grant ack0=%0d ack1=%0d", bus_a.Ack0, bus_a.Ack1);
        bus_a.Req0 = 1'b0;
        bus_a.Req1 = 1'b0;
        wait_idle_a();

        // Single frame, then a frame whose Data0 changes during shifting.
        frame0(4'b1011, 4'b1011, "single");
        frame0(4'b1001, 4'b0110, "ignchg");

        // Contention: fresh reset so requester 0 wins the first tie.
        rst_a_n = 1'b0;
        tick();
        chk("cont_rst_outs", outs_a, 0);
        rst_a_n     = 1'b1;
        bus_a.Req0  = 1'b1;
        bus_a.Req1  = 1'b1;
        bus_a.Data0 = 4'b1100;
        bus_a.Data1 = 4'b0011;
        grants = 0;
        for (int c = 1; c <= 28; c++) begin
            tick();
            chk("cont_load", bus_a.Load, ((c % 7) == 1));
            chk("cont_excl", bus_a.Load & bus_a.ShiftEn, 0);
            if ((c % 7) == 1) begin
                exp_src = grants[0];
                chk("cont_ack0", bus_a.Ack0, !exp_src);
                chk("cont_ack1", bus_a.Ack1, exp_src);
                chk("cont_pin", bus_a.ParallelIn, exp_src ? 4'b0011 : 4'b1100);
                chk("cont_src", bus_a.SerSrc, exp_src);
                $display("contention cycle %0d: grant=%0d word=%b", c, exp_src, bus_a.ParallelIn);
                grants++;
            end
        end
        bus_a.Req0 = 1'b0;
        bus_a.Req1 = 1'b0;
        wait_idle_a();

        // Mid-frame reset on the second shift cycle.
        bus_a.Req0  = 1'b1;
        bus_a.Data0 = 4'b1011;
        tick();
        chk("mrst_load", bus_a.Load, 1);
        bus_a.Req0 = 1'b0;
        tick();
        tick();
        chk("mrst_shift2", bus_a.ShiftEn, 1);
        rst_a_n     = 1'b0;
        bus_a.Req1  = 1'b1;
        bus_a.Data1 = 4'b0110;
        tick();
        chk("mrst_outs", outs_a, 0);
        rst_a_n = 1'b1;
        tick();
        chk("mrst_reload", bus_a.Load, 1);
        chk("mrst_ack1", bus_a.Ack1, 1);
        chk("mrst_ack0", bus_a.Ack0, 0);
        chk("mrst_pin", bus_a.ParallelIn, 4'b0110);
        chk("mrst_src", bus_a.SerSrc, 1);
        $display("mid-frame reset: fresh load src=1 word=%b", bus_a.ParallelIn);
        bus_a.Req1 = 1'b0;
        wait_idle_a();

        // Zero-gap instance with Req1 held: one idle cycle, period 6.
        bus_b.Req1  = 1'b1;
        bus_b.Data1 = 4'b0101;
        tick();
        rst_b_n = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk("gap0_load", bus_b.Load, ((c % 6) == 1));
            chk("gap0_busy", bus_b.Busy, ((c % 6) != 0));
            if ((c % 6) == 1) begin
                chk("gap0_ack1", bus_b.Ack1, 1);
                $display("gap0 cycle %0d: load word=%b", c, bus_b.ParallelIn);
            end
        end
        bus_b.Req1 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
